potential_decay_array: RTL and testbench
========================================

# potential_decay_array

Parametrised, multi-neuron successor to the single-neuron potential decay unit. It stores membrane potentials (IEEE-754 single) plus per-neuron decay rate and model for `N_NEURONS` neurons. On each timestep it sweeps all neurons one per cycle, applies the exponent-shift decay, writes the result back and streams it out. It sits between the potential adder (update writes) and the spike/threshold stage (decayed stream).

## Interface
- `N_NEURONS`, 16, neurons held; any value ≥ 2.
- `ADDR_W`, 4, neuron index width; must satisfy 2^ADDR_W ≥ N_NEURONS.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `timestep`  in  1  one-cycle pulse that starts a decay sweep.
- `upd_valid`  in  1  write request.
- `upd_init`  in  1  when high with `upd_valid`, also write `upd_rate` and `upd_model`.
- `upd_addr`  in  ADDR_W  target neuron.
- `upd_potential`  in  32  new potential value.
- `upd_rate`  in  4  decay code.
- `upd_model`  in  2  00 = LIF; other values are pass-through.
- `upd_ready`  out  1  high when a write can be accepted (`!busy`).
- `out_valid`  out  1  decayed value valid.
- `out_addr`  out  ADDR_W  neuron index of `out_potential`.
- `out_potential`  out  32  decayed potential.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last neuron is output.
- `overrun`  out  1  sticky; set when `timestep` arrives while busy.

## Operation
- **Storage.** Per-neuron potential (32 bits), rate (4 bits) and model (2 bits).
  - Reset clears all potentials to 0x00000000, rates to 4'b0001 and models to 00.
- **Writes.** A write is accepted only when `upd_valid && upd_ready`.
  - It overwrites the potential of `upd_addr`, and also the rate and model when `upd_init` is high.
  - A write to an address ≥ N_NEURONS is ignored.
- **FSM states.**
  - IDLE → SWEEP on `timestep`.
  - SWEEP issues indices 0..N_NEURONS-1, one per cycle, then → DRAIN.
  - DRAIN waits for the pipeline to empty, then → DONE.
  - DONE pulses `done`, then → IDLE.
- **Decay rule.** Operand is sign s, exponent e, mantissa m.
  - Code 0001: divide by 1.
  - Codes 0010, 0100, 1000: divide by 2, 4 or 8 (shift k = 1, 2, 3), giving e' = e − k.
  - Code 0011 (×0.75): form 24-bit S = {1,m} and compute T = S + (S>>1) as 25 bits, truncated.
    - If T[24] = 1: result is {s, e, T[23:1]}.
    - Otherwise: result is {s, e−1, T[22:0]}.
  - Any other code: divide by 1.
- **Boundary rules for the decay.**
  - e = 255 (inf/NaN): pass unchanged.
  - e = 0: output {s, 31'b0}.
  - Resulting exponent ≤ 0: flush to {s, 31'b0}.
  - Model ≠ 00: value passes unchanged.
- **Write-back.** The decayed value is written back to the neuron in the same cycle `out_valid` is high.
- **Timestep handling.**
  - `timestep` while busy is ignored and sets `overrun`; only `reset` clears `overrun`.
  - `timestep` and an accepted write in the same IDLE cycle: the write lands first, so the sweep sees the new value.
- **Reset mid-sweep.** The sweep is aborted, storage is cleared and no `done` is produced.

## Timing
- Reset values: `out_valid` 0, `out_addr` 0, `out_potential` 0, `busy` 0, `done` 0, `overrun` 0, `upd_ready` 1.
- `timestep` is sampled high in cycle T (IDLE):
  - `busy` rises in T+1.
  - Neuron k is read in T+1+k (registered read).
  - Decay stage is registered, so `out_valid` for neuron k is high in T+2+k.
  - `done` is high in T+2+N_NEURONS.
  - `busy` falls in T+3+N_NEURONS.
- `out_valid` is high for N_NEURONS consecutive cycles with `out_addr` ascending 0..N_NEURONS-1, with no bubbles.
- `upd_ready` is low for the whole sweep, T+1 through T+2+N_NEURONS.
- A new `timestep` is accepted from T+3+N_NEURONS onward.

## Test plan
- **Reset.** Assert `reset`, then pulse `timestep` → 16 `out_valid` cycles, all `out_potential` = 0x00000000; `done` at T+18; `overrun` = 0.
- **Divide by 2.** Init neuron 0 = 0x41DED852 with rate 0010, then `timestep` → `out_addr` 0, `out_potential` 0x415ED852 at T+2. A second sweep gives 0x40DED852.
- **×0.75 both normalise paths.**
  - Neuron 1 = 0x41000000 (8.0), rate 0011 → 0x40C00000 (6.0).
  - Neuron 2 = 0x3FC00000 (1.5), rate 0011 → 0x3F900000 (1.125).
- **Divide by 8, underflow, special values.**
  - 0x3C000000, rate 1000 → 0x3A800000.
  - 0x81000000, rate 1000 → 0x80000000.
  - 0x7FC00000, rate 1000 → 0x7FC00000 unchanged.
  - Model 01 with 0x40400000 → unchanged.
- **Overrun and blocked writes.** Pulse `timestep` at T+5 during a sweep, and drive `upd_valid` at T+4 →
  - `overrun` = 1 from T+6;
  - no restart; exactly 16 outputs;
  - `upd_ready` = 0 and the write is not applied.
- **Simultaneous write and timestep; reset mid-sweep.**
  - Write neuron 3 = 0x40800000 (rate 0010) in the same cycle as `timestep` → neuron 3 outputs 0x40000000.
  - Assert `reset` at T+6 → outputs cease, no `done`, all storage reads 0 on the next sweep.

Source files
------------

// File: rtl/potential_decay_array.sv
// Multi-neuron membrane potential store with a timestep-driven exponent-shift decay sweep.
// Each sweep reads, decays, streams out and writes back every neuron in ascending order.
module potential_decay_array #(
   parameter int N_NEURONS = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              timestep,
   input  logic              upd_valid,
   input  logic              upd_init,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [31:0]       upd_potential,
   input  logic [3:0]        upd_rate,
   input  logic [1:0]        upd_model,
   output logic              upd_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_potential,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] idx;
   logic              wr_en;

   logic [31:0] pot_mem   [N_NEURONS];
   logic [3:0]  rate_mem  [N_NEURONS];
   logic [1:0]  model_mem [N_NEURONS];

   logic [31:0] rd_pot;
   logic [3:0]  rd_rate;
   logic [1:0]  rd_model;
   logic [31:0] decayed;
   logic        sign;
   logic [7:0]  exp_in;
   logic [22:0] man_in;
   logic [23:0] s_ext;
   logic [24:0] t_sum;
   logic [1:0]  shift;

   assign wr_en = upd_valid && upd_ready && (32'(upd_addr) < N_NEURONS);

   // Write-back of the decayed stream and external updates never collide: updates need !busy.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            pot_mem[i]   <= 32'h0000_0000;
            rate_mem[i]  <= 4'b0001;
            model_mem[i] <= 2'b00;
         end
      end else if (out_valid) begin
         pot_mem[out_addr] <= out_potential;
      end else if (wr_en) begin
         pot_mem[upd_addr] <= upd_potential;
         if (upd_init) begin
            rate_mem[upd_addr]  <= upd_rate;
            model_mem[upd_addr] <= upd_model;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (timestep) begin
               next_state = SWEEP;
            end
         end
         SWEEP: begin
            if (idx == LAST_IDX) begin
               next_state = DRAIN;
            end
         end
         DRAIN: next_state = DONE;
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      upd_ready = !busy;
   end

   // The index register acts as the registered read address; the decay result is registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx           <= '0;
         overrun       <= 1'b0;
         out_valid     <= 1'b0;
         out_addr      <= '0;
         out_potential <= 32'h0000_0000;
      end else begin
         if (state == SWEEP) begin
            idx <= idx + ADDR_W'(1);
         end else begin
            idx <= '0;
         end
         if (timestep && busy) begin
            overrun <= 1'b1;
         end
         out_valid <= (state == SWEEP);
         if (state == SWEEP) begin
            out_addr      <= idx;
            out_potential <= decayed;
         end
      end
   end

   assign rd_pot   = pot_mem[idx];
   assign rd_rate  = rate_mem[idx];
   assign rd_model = model_mem[idx];

   // x0.75 keeps the exponent when S + S/2 carries into bit 24, otherwise drops it by one.
   always_comb begin
      sign    = rd_pot[31];
      exp_in  = rd_pot[30:23];
      man_in  = rd_pot[22:0];
      s_ext   = {1'b1, man_in};
      t_sum   = {1'b0, s_ext} + {2'b00, s_ext[23:1]};
      shift   = 2'd0;
      decayed = rd_pot;
      if (rd_model != 2'b00 || exp_in == 8'hFF) begin
         decayed = rd_pot;
      end else if (exp_in == 8'h00) begin
         decayed = {sign, 31'b0};
      end else if (rd_rate == 4'b0011) begin
         if (t_sum[24]) begin
            decayed = {sign, exp_in, t_sum[23:1]};
         end else if (exp_in == 8'd1) begin
            decayed = {sign, 31'b0};
         end else begin
            decayed = {sign, exp_in - 8'd1, t_sum[22:0]};
         end
      end else begin
         case (rd_rate)
            4'b0010: shift = 2'd1;
            4'b0100: shift = 2'd2;
            4'b1000: shift = 2'd3;
            default: shift = 2'd0;
         endcase
         if (exp_in <= {6'b0, shift}) begin
            decayed = {sign, 31'b0};
         end else begin
            decayed = {sign, exp_in - {6'b0, shift}, man_in};
         end
      end
   end

endmodule

// File: tb/tb_potential_decay_array.sv
// Self-checking bench for potential_decay_array: directed plan steps plus randomized
// neuron contents, checked cycle by cycle against an arithmetic reference model.
module tb_potential_decay_array;

   localparam int N = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        timestep;
   logic        upd_valid;
   logic        upd_init;
   logic [3:0]  upd_addr;
   logic [31:0] upd_potential;
   logic [3:0]  upd_rate;
   logic [1:0]  upd_model;
   logic        upd_ready;
   logic        out_valid;
   logic [3:0]  out_addr;
   logic [31:0] out_potential;
   logic        busy;
   logic        done;
   logic        overrun;

   int          tests = 0;
   int          failures = 0;

   logic [31:0] ref_pot   [N];
   logic [3:0]  ref_rate  [N];
   logic [1:0]  ref_model [N];
   logic        ref_overrun;
   logic [31:0] captured  [N];

   potential_decay_array #(.N_NEURONS(N), .ADDR_W(4)) dut (
      .clock(clock), .reset(reset), .timestep(timestep),
      .upd_valid(upd_valid), .upd_init(upd_init), .upd_addr(upd_addr),
      .upd_potential(upd_potential), .upd_rate(upd_rate), .upd_model(upd_model),
      .upd_ready(upd_ready), .out_valid(out_valid), .out_addr(out_addr),
      .out_potential(out_potential), .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference: value * 2^-k or value * 0.75 (truncated), computed on the integer significand.
   function automatic logic [31:0] ref_decay(input logic [31:0] v, input logic [3:0] rate,
                                             input logic [1:0] model);
      int     e;
      int     k;
      longint sig;
      longint q;
      e = int'(v[30:23]);
      if (model != 2'b00 || e == 255) return v;
      if (e == 0) return {v[31], 31'b0};
      sig = longint'({1'b1, v[22:0]});
      if (rate == 4'b0011) begin
         q = (sig * 3) / 2;
         if (q >= 64'd16777216) q = q / 2;
         else e = e - 1;
         if (e <= 0) return {v[31], 31'b0};
         return {v[31], e[7:0], q[22:0]};
      end
      case (rate)
         4'b0010: k = 1;
         4'b0100: k = 2;
         4'b1000: k = 3;
         default: k = 0;
      endcase
      e = e - k;
      if (e <= 0) return {v[31], 31'b0};
      return {v[31], e[7:0], v[22:0]};
   endfunction

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         ref_pot[i]   = 32'h0;
         ref_rate[i]  = 4'b0001;
         ref_model[i] = 2'b00;
      end
      ref_overrun = 1'b0;
   endtask

   task automatic drive_write(input logic [3:0] addr, input logic [31:0] pot, input logic init,
                              input logic [3:0] rate, input logic [1:0] model);
      upd_valid     = 1'b1;
      upd_init      = init;
      upd_addr      = addr;
      upd_potential = pot;
      upd_rate      = rate;
      upd_model     = model;
      if (int'(addr) < N) begin
         ref_pot[addr] = pot;
         if (init) begin
            ref_rate[addr]  = rate;
            ref_model[addr] = model;
         end
      end
   endtask

   task automatic apply_write(input logic [3:0] addr, input logic [31:0] pot, input logic init,
                              input logic [3:0] rate, input logic [1:0] model);
      drive_write(addr, pot, init, rate, model);
      tick();
      upd_valid = 1'b0;
      upd_init  = 1'b0;
   endtask

   // Cycle offsets are relative to the cycle T in which timestep is driven high.
   task automatic run_sweep(input int ts_at, input int wr_at, input int abort_at);
      logic [31:0] exp_val;
      int          k;
      timestep = 1'b1;
      tick();
      timestep  = 1'b0;
      upd_valid = 1'b0;
      upd_init  = 1'b0;
      for (int cyc = 1; cyc <= N + 2; cyc++) begin
         check($sformatf("busy@T+%0d", cyc), busy, 1'b1);
         check($sformatf("upd_ready@T+%0d", cyc), upd_ready, 1'b0);
         check($sformatf("done@T+%0d", cyc), done, (cyc == N + 2));
         check($sformatf("overrun@T+%0d", cyc), overrun, ref_overrun);
         if (cyc >= 2 && cyc <= N + 1) begin
            k = cyc - 2;
            exp_val = ref_decay(ref_pot[k], ref_rate[k], ref_model[k]);
            check($sformatf("out_valid@T+%0d", cyc), out_valid, 1'b1);
            check($sformatf("out_addr@T+%0d", cyc), out_addr, k[3:0]);
            check($sformatf("out_potential[%0d]", k), out_potential, exp_val);
            captured[k] = out_potential;
            ref_pot[k]  = exp_val;
         end else begin
            check($sformatf("out_valid@T+%0d", cyc), out_valid, 1'b0);
         end
         if (cyc == ts_at) begin
            timestep    = 1'b1;
            ref_overrun = 1'b1;
         end
         if (cyc == wr_at) begin
            upd_valid     = 1'b1;
            upd_init      = 1'b1;
            upd_addr      = 4'd9;
            upd_potential = $urandom | 32'h4000_0000;
            upd_rate      = 4'b0100;
            upd_model     = 2'b00;
         end
         if (cyc == abort_at) reset = 1'b1;
         tick();
         timestep  = 1'b0;
         upd_valid = 1'b0;
         upd_init  = 1'b0;
         if (cyc == abort_at) begin
            reset = 1'b0;
            reset_model();
            check("abort_out_valid", out_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_overrun", overrun, 1'b0);
            check("abort_out_potential", out_potential, 32'h0);
            for (int j = 0; j < N + 4; j++) begin
               check("abort_no_done", done, 1'b0);
               check("abort_no_output", out_valid, 1'b0);
               tick();
            end
            return;
         end
      end
      check("busy_fall", busy, 1'b0);
      check("ready_back", upd_ready, 1'b1);
      check("done_pulse_end", done, 1'b0);
      check("no_extra_output", out_valid, 1'b0);
      check("overrun_after", overrun, ref_overrun);
      tick();
      check("no_restart_busy", busy, 1'b0);
      check("no_restart_valid", out_valid, 1'b0);
   endtask

   function automatic logic [31:0] rand_potential();
      logic [7:0] e;
      case ($urandom_range(0, 5))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2:       e = 8'($urandom_range(1, 4));
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   function automatic logic [3:0] rand_rate();
      case ($urandom_range(0, 6))
         0:       return 4'b0001;
         1:       return 4'b0010;
         2, 3:    return 4'b0011;
         4:       return 4'b0100;
         5:       return 4'b1000;
         default: return 4'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1; timestep = 1'b0; upd_valid = 1'b0; upd_init = 1'b0;
      upd_addr = '0; upd_potential = '0; upd_rate = '0; upd_model = '0;
      reset_model();
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_addr", out_addr, 4'd0);
      check("rst_out_potential", out_potential, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_upd_ready", upd_ready, 1'b1);

      $display("[TB] reset sweep");
      run_sweep(-1, -1, -1);
      check("rst_sweep_n15", captured[15], 32'h0);

      $display("[TB] directed decay values");
      apply_write(4'd0, 32'h41DE_D852, 1'b1, 4'b0010, 2'b00);
      apply_write(4'd1, 32'h4100_0000, 1'b1, 4'b0011, 2'b00);
      apply_write(4'd2, 32'h3FC0_0000, 1'b1, 4'b0011, 2'b00);
      apply_write(4'd4, 32'h3C00_0000, 1'b1, 4'b1000, 2'b00);
      apply_write(4'd5, 32'h8100_0000, 1'b1, 4'b1000, 2'b00);
      apply_write(4'd6, 32'h7FC0_0000, 1'b1, 4'b1000, 2'b00);
      apply_write(4'd7, 32'h4040_0000, 1'b1, 4'b0010, 2'b01);
      run_sweep(-1, -1, -1);
      check("div2_first", captured[0], 32'h415E_D852);
      check("mul075_8p0", captured[1], 32'h40C0_0000);
      check("mul075_1p5", captured[2], 32'h3F90_0000);
      check("div8_normal", captured[4], 32'h3A80_0000);
      check("div8_underflow", captured[5], 32'h8000_0000);
      check("div8_nan", captured[6], 32'h7FC0_0000);
      check("model01_pass", captured[7], 32'h4040_0000);
      run_sweep(-1, -1, -1);
      check("div2_second", captured[0], 32'h40DE_D852);

      $display("[TB] write with timestep in same cycle");
      drive_write(4'd3, 32'h4080_0000, 1'b1, 4'b0010, 2'b00);
      run_sweep(-1, -1, -1);
      check("same_cycle_write", captured[3], 32'h4000_0000);

      $display("[TB] overrun and blocked write");
      run_sweep(5, 4, -1);
      run_sweep(-1, -1, -1);

      $display("[TB] reset mid-sweep");
      run_sweep(-1, -1, 6);
      run_sweep(-1, -1, -1);
      check("post_abort_n0", captured[0], 32'h0);

      $display("[TB] randomized neuron contents");
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            apply_write(4'(i), rand_potential(), 1'b1, rand_rate(),
                        ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         end
         run_sweep(-1, -1, -1);
         for (int w = 0; w < 3; w++) begin
            apply_write(4'($urandom_range(0, N - 1)), rand_potential(), 1'b0, 4'b0, 2'b0);
         end
         run_sweep(-1, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
